// File: rtl/io_port_responder_if.sv
// Port-bus bundle between the control unit (master) and the port responder (slave).
interface io_port_responder_if #(
    parameter int DW = 32,
    parameter int AW = 2
);
    logic          port_cyc_i;
    logic          port_stb_i;
    logic          port_we_i;
    logic [AW:0]   port_adr_i;
    logic [DW-1:0] port_dat_i;
    logic [DW-1:0] port_dat_o;
    logic          port_ack_o;

    modport master (
        output port_cyc_i, port_stb_i, port_we_i, port_adr_i, port_dat_i,
        input  port_dat_o, port_ack_o
    );

    modport slave (
        input  port_cyc_i, port_stb_i, port_we_i, port_adr_i, port_dat_i,
        output port_dat_o, port_ack_o
    );
endinterface

// File: rtl/io_port_responder.sv
// Port-bus responder: wait-stated acknowledge, output registers, synchronized
// input ports with change detection feeding a priority interrupt request.

module io_port_responder_lane #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] pin_i,
    output logic [DW-1:0] sync_o,
    output logic          chg_o
);
    logic [DW-1:0] sync1_q, sync1_d;
    logic [DW-1:0] sync2_q, sync2_d;
    logic [DW-1:0] prev_q,  prev_d;

    always_comb begin
        sync1_d = pin_i;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign sync_o = sync2_q;
    assign chg_o  = (sync2_q != prev_q);
endmodule

module io_port_responder #(
    parameter int NPORTS      = 4,
    parameter int DW          = 32,
    parameter int AW          = 2,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    io_port_responder_if.slave   bus,
    input  logic [NPORTS*DW-1:0] in_i,
    output logic [NPORTS*DW-1:0] out_o,
    output logic                 int_req_o,
    output logic [AW-1:0]        int_src_o,
    input  logic                 int_ack_i
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    logic [NPORTS-1:0][DW-1:0] sync_w;
    logic [NPORTS-1:0]         chg_w;

    for (genvar p = 0; p < NPORTS; p++) begin : g_lane
        io_port_responder_lane #(.DW(DW)) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .pin_i  (in_i[p*DW +: DW]),
            .sync_o (sync_w[p]),
            .chg_o  (chg_w[p])
        );
    end

    state_t                    state_q, state_d;
    logic [3:0]                cnt_q,   cnt_d;
    logic [AW:0]               adr_q,   adr_d;
    logic                      we_q,    we_d;
    logic [DW-1:0]             wdat_q,  wdat_d;
    logic [NPORTS-1:0][DW-1:0] out_q,   out_d;
    logic [DW-1:0]             dat_q,   dat_d;
    logic                      ack_q,   ack_d;
    logic [NPORTS-1:0]         pend_q,  pend_d;

    logic                      enter_ack;
    logic [AW:0]               eff_adr;
    logic                      eff_we;
    logic [DW-1:0]             eff_dat;

    // With zero wait states the request goes straight to ACK, so the transfer
    // must act on the live bus inputs rather than the not-yet-latched copies.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        adr_d     = adr_q;
        we_d      = we_q;
        wdat_d    = wdat_q;
        out_d     = out_q;
        dat_d     = '0;
        ack_d     = 1'b0;
        enter_ack = 1'b0;
        eff_adr   = adr_q;
        eff_we    = we_q;
        eff_dat   = wdat_q;
        case (state_q)
            S_IDLE: begin
                if (bus.port_cyc_i && bus.port_stb_i) begin
                    adr_d   = bus.port_adr_i;
                    we_d    = bus.port_we_i;
                    wdat_d  = bus.port_dat_i;
                    cnt_d   = WAIT_INIT;
                    eff_adr = bus.port_adr_i;
                    eff_we  = bus.port_we_i;
                    eff_dat = bus.port_dat_i;
                    if (WAIT_INIT == 4'd0) begin
                        state_d   = S_ACK;
                        enter_ack = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!bus.port_cyc_i) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d   = S_ACK;
                        enter_ack = 1'b1;
                    end
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (enter_ack) begin
            ack_d = 1'b1;
            if (eff_we) begin
                if (eff_adr[AW]) out_d[eff_adr[AW-1:0]] = eff_dat;
            end else begin
                dat_d = eff_adr[AW] ? out_q[eff_adr[AW-1:0]] : sync_w[eff_adr[AW-1:0]];
            end
        end
    end

    logic [AW-1:0]     src_w;
    logic [NPORTS-1:0] clr_w;

    always_comb begin
        src_w = '0;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            if (pend_q[i]) src_w = AW'(i);
        end
        clr_w        = '0;
        clr_w[src_w] = int_ack_i;
        // A fresh change on the acknowledged port keeps it pending.
        pend_d       = (pend_q & ~clr_w) | chg_w;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            wdat_q  <= '0;
            out_q   <= '0;
            dat_q   <= '0;
            ack_q   <= 1'b0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            we_q    <= we_d;
            wdat_q  <= wdat_d;
            out_q   <= out_d;
            dat_q   <= dat_d;
            ack_q   <= ack_d;
            pend_q  <= pend_d;
        end
    end

    assign bus.port_ack_o = ack_q;
    assign bus.port_dat_o = dat_q;
    assign out_o          = out_q;
    assign int_req_o      = |pend_q;
    assign int_src_o      = src_w;
endmodule

// File: doc/io_port_responder.md
# io_port_responder

Responder end of the processor's port bus: answers the control unit's port strobe/cycle/write-enable requests with a registered acknowledge after a programmable number of wait states, holds output-port registers and samples synchronized input ports. Also originates the interrupt request the control unit consumes, and retires it on the control unit's interrupt acknowledge. Sits between the datapath's port interface and the external pins.

## Interface

- `NPORTS`, default 4: number of input ports and number of output ports.
- `DW`, default 32: port data width.
- `AW`, default 2: log2(NPORTS); port index width.
- `WAIT_CYCLES`, default 1: wait states inserted before acknowledge; 0 to 15.

Ports (name, direction, width, meaning):

- `clk` in 1: single clock; everything is on its rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `port_cyc_i` in 1: bus cycle valid.
- `port_stb_i` in 1: transfer strobe.
- `port_we_i` in 1: 1 = write, 0 = read.
- `port_adr_i` in AW+1: bit AW = 0 selects input port, 1 selects output register; [AW-1:0] = port index.
- `port_dat_i` in DW: write data.
- `port_dat_o` out DW: read data, valid only while `port_ack_o` = 1, else 0.
- `port_ack_o` out 1: one-cycle acknowledge.
- `in_i` in NPORTS*DW: asynchronous input pins; port p is bits [p*DW +: DW].
- `out_o` out NPORTS*DW: output-register contents, same packing.
- `int_req_o` out 1: interrupt request to the control unit.
- `int_src_o` out AW: lowest-index pending port.
- `int_ack_i` in 1: interrupt acknowledge from the control unit (one-cycle pulse).

## Operation

- Bus FSM has three states: IDLE, WAIT and ACK.
  - IDLE: when `port_cyc_i & port_stb_i`, latch the address, we and data, and load the wait counter with WAIT_CYCLES. Go to ACK if WAIT_CYCLES = 0, else go to WAIT.
  - WAIT: decrement the counter. At count 1, go to ACK. If `port_cyc_i` = 0, abort to IDLE with no write and no ack.
  - ACK: `port_ack_o` = 1 for exactly this cycle, then IDLE unconditionally. Requests present during ACK are not sampled.
- Write to output register p (adr[AW] = 1): `out_o` port p takes the latched data on the edge that enters ACK.
- Write to an input address: no effect, still acknowledged.
- Read: `port_dat_o` is registered on the edge entering ACK.
  - adr[AW] = 0: synchronized input of port p.
  - adr[AW] = 1: output register p.
- Input path: each bit goes through a 2-flop synchronizer, then a previous-value register. Any difference between the synchronized and previous value of port p sets `pending[p]`.
- `int_req_o` = OR of `pending`, driven directly from registers.
- `int_src_o` = lowest index with `pending` set, 0 if none.
- `int_ack_i` = 1 at an edge clears `pending[int_src_o]`.
  - If port p has a new change on the same edge that clears p, set wins: the bit stays 1.
  - `int_ack_i` with nothing pending has no effect.
- Reset values:
  - Outputs: `out_o`, `port_dat_o`, `port_ack_o`, `int_req_o` and `int_src_o` are all 0.
  - Internal state: FSM IDLE, counter 0, synchronizers, previous-value registers and `pending` all 0.
  - Nonzero pins present at reset release are detected as changes and raise `pending`.
- Reset asserted mid-transaction: immediate return to the reset values. No ack and no write are produced.

## Timing

- Ack latency: request sampled at edge E0 ⇒ `port_ack_o` high during the cycle after edge E0+WAIT_CYCLES.
  - Total: WAIT_CYCLES+1 cycles from sampling to the ack cycle.
- Back-to-back: the earliest next sample is the first IDLE edge after ACK. Minimum period is WAIT_CYCLES+2 cycles per transfer.
- Input change on `in_i` set up before edge S1 ⇒ `pending` and `int_req_o` high after edge S3 (3-cycle latency).
- `int_ack_i` sampled at edge A ⇒ `int_req_o` low after A if that was the only pending bit. Otherwise `int_src_o` updates to the next pending index after A.
- Bus side and interrupt side are independent; simultaneous activity on both does not interact.

## Test plan

- Reset and read: `rst_n` low with in_i port 1 = 0xA5, then release ⇒ all outputs 0 during reset. Then read adr=3'b001, WAIT_CYCLES=1 ⇒ ack in the 2nd cycle after sampling with `port_dat_o` = 0xA5, and 0 on the cycles around it.
- Write and read back: write 0xDEADBEEF to adr=3'b110 ⇒ `out_o` port 2 = 0xDEADBEEF on the ack edge. A following read of adr=3'b110 returns 0xDEADBEEF. Other ports are unchanged.
- Wait states and abort: WAIT_CYCLES=3, drop `port_cyc_i` in the 2nd WAIT cycle ⇒ no ack and `out_o` unchanged. WAIT_CYCLES=0 ⇒ ack in the cycle right after sampling.
- Interrupt priority: change ports 3 and 1 in the same cycle ⇒ `int_req_o`=1 three edges later with `int_src_o`=1. After one `int_ack_i`, `int_src_o`=3. After a second, `int_req_o`=0.
- Set wins: port 0 changes again on the same edge that acknowledges port 0 ⇒ `pending[0]` stays 1 and `int_req_o` stays 1.
- Reset mid-transfer: assert `rst_n`=0 during WAIT of a write ⇒ no ack and `out_o` = 0. After release, the FSM accepts a new request normally.
